sll_multicycle: RTL and testbench

//  Iterative logical-left shifter for the ALU shift path; the left-direction counterpart of the

---
 rtl/sll_multicycle_pkg.sv | 15 +
 rtl/sll_stage.sv | 18 +
 rtl/sll_multicycle.sv | 116 +++++++++++
 tb/tb_sll_multicycle.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sll_multicycle_pkg.sv
// Shared ALU shift-path package.
// Holds the operand/shift-amount sizing used by the iterative left shifter and the
// state encoding of its controller (two-bit IDLE/SHIFT/DONE).
package sll_multicycle_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sll_stage.sv
// Fixed-distance logical left shift, purely combinational.
// One instance exists per power-of-two distance; the controller picks which one to apply.
// Ports:
//   in   operand to shift
//   out  in << DIST, zeros filled into the LSBs, MSBs discarded
module sll_stage
    import sll_multicycle_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int DIST    = 1
) (
    input  logic [WIDTH_P-1:0] in,
    output logic [WIDTH_P-1:0] out
);

    assign out = in << DIST;

endmodule

// File: rtl/sll_multicycle.sv
// Iterative logical-left shifter for the ALU shift path.
// A start pulse captures the operand and shift amount; the 16/8/4/2/1 stages are then
// applied one per cycle, MSB first, and the result is presented with a one-cycle ready
// pulse. Latency is fixed at SHAMT_W cycles whatever the shift amount is.
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous, active-low reset
//   ctrl_shift      start pulse, honoured only in IDLE or DONE
//   data_operandA   operand captured on an accepted start
//   ctrl_shamt      shift amount captured on an accepted start
//   data_result     last completed result, updated only on completion
//   data_resultRDY  high for the single cycle the controller sits in DONE
//   busy            high while the shift is in progress
module sll_multicycle
    import sll_multicycle_pkg::*;
#(
    parameter int WIDTH_P   = WIDTH,
    parameter int SHAMT_W_P = SHAMT_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ctrl_shift,
    input  logic [WIDTH_P-1:0]   data_operandA,
    input  logic [SHAMT_W_P-1:0] ctrl_shamt,
    output logic [WIDTH_P-1:0]   data_result,
    output logic                 data_resultRDY,
    output logic                 busy
);

    localparam int STAGE_W = (SHAMT_W_P > 1) ? $clog2(SHAMT_W_P) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W_P - 1);

    state_t                 state;
    logic [STAGE_W-1:0]     stage;
    logic [WIDTH_P-1:0]     acc;
    logic [SHAMT_W_P-1:0]   shamt_q;
    logic [WIDTH_P-1:0]     stageOut [SHAMT_W_P];
    logic [WIDTH_P-1:0]     stageSel;

    // Stage i shifts by 2**i; all of them look at the accumulator every cycle.
    for (genvar i = 0; i < SHAMT_W_P; i++) begin : g_stage
        sll_stage #(
            .WIDTH_P (WIDTH_P),
            .DIST    (1 << i)
        ) u_stage (
            .in  (acc),
            .out (stageOut[i])
        );
    end

    // Only the stage matching the current counter position is applied, and only when the
    // corresponding shift-amount bit is set; otherwise the accumulator passes through.
    always_comb begin
        stageSel = acc;
        if (shamt_q[stage]) begin
            stageSel = stageOut[stage];
        end
    end

    // Controller: a start is taken in IDLE or DONE, so back-to-back ops still get their
    // ready pulse. busy and data_resultRDY are registered alongside the state so they
    // always reflect SHIFT and DONE respectively.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            stage          <= LAST_STAGE;
            acc            <= '0;
            shamt_q        <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_shift) begin
                        acc     <= data_operandA;
                        shamt_q <= ctrl_shamt;
                        stage   <= LAST_STAGE;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= stageSel;
                    if (stage == '0) begin
                        // Final stage: publish including this cycle's shift.
                        data_result    <= stageSel;
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                    end else begin
                        stage <= stage - 1'b1;
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_shift) begin
                        acc     <= data_operandA;
                        shamt_q <= ctrl_shamt;
                        stage   <= LAST_STAGE;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sll_multicycle.sv
// Directed and random bench for the iterative left shifter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sll_multicycle;

    logic        clock;
    logic        reset_n;
    logic        ctrl_shift;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int          checkCount;
    int          errorCount;
    logic [31:0] prevResult;

    sll_multicycle dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_shift     (ctrl_shift),
        .data_operandA  (data_operandA),
        .ctrl_shamt     (ctrl_shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Issues a start at the current falling edge; returns one cycle later with the
    // start already sampled by the rising edge in between.
    task automatic applyStimulus(input logic [31:0] a, input logic [4:0] sh);
        data_operandA = a;
        ctrl_shamt    = sh;
        ctrl_shift    = 1'b1;
        @(negedge clock);
        ctrl_shift    = 1'b0;
    endtask

    // Follows one operation through SHIFT into DONE. Called right after the accepting
    // edge; returns at the falling edge inside the DONE cycle. Optionally pokes a
    // start with different data while shifting, which must have no effect.
    task automatic waitResult(input string tag, input logic [31:0] expected,
                              input bit pokeMid);
        checkOutput({tag, " busy0"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " rdy0"}, {31'd0, data_resultRDY}, 32'd0);
        checkOutput({tag, " hold0"}, data_result, prevResult);
        for (int c = 1; c < 5; c++) begin
            if (pokeMid && c == 2) begin
                data_operandA = 32'h1234_5678;
                ctrl_shamt    = 5'd3;
                ctrl_shift    = 1'b1;
            end
            @(negedge clock);
            ctrl_shift = 1'b0;
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " rdy"}, {31'd0, data_resultRDY}, 32'd0);
            checkOutput({tag, " hold"}, data_result, prevResult);
        end
        @(negedge clock);
        checkOutput({tag, " doneRdy"}, {31'd0, data_resultRDY}, 32'd1);
        checkOutput({tag, " doneBusy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " result"}, data_result, expected);
        prevResult = expected;
    endtask

    // One cycle after DONE with no new start the block should sit idle, result held.
    task automatic checkIdle(input string tag);
        @(negedge clock);
        checkOutput({tag, " idleRdy"}, {31'd0, data_resultRDY}, 32'd0);
        checkOutput({tag, " idleBusy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " idleResult"}, data_result, prevResult);
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  sh;

        checkCount    = 0;
        errorCount    = 0;
        prevResult    = 32'd0;
        reset_n       = 1'b0;
        ctrl_shift    = 1'b0;
        data_operandA = 32'd0;
        ctrl_shamt    = 5'd0;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("reset result", data_result, 32'd0);
        checkOutput("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Shift a single bit all the way to the top.
        applyStimulus(32'h0000_0001, 5'd31);
        waitResult("one<<31", 32'h8000_0000, 1'b0);
        checkIdle("one<<31");

        // Zero shift still takes the full latency.
        applyStimulus(32'hDEAD_BEEF, 5'd0);
        waitResult("shamt0", 32'hDEAD_BEEF, 1'b0);
        checkIdle("shamt0");

        // Start pulsed mid-shift is ignored; then a back-to-back start taken in DONE.
        applyStimulus(32'h8765_4321, 5'd12);
        waitResult("sh12", 32'h5432_1000, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 5'd8);
        waitResult("b2b", 32'hFFFF_FF00, 1'b0);
        checkIdle("b2b");

        // Reset in the middle of a shift aborts it and clears the outputs at once.
        applyStimulus(32'h0000_0003, 5'd1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midReset result", data_result, 32'd0);
        checkOutput("midReset rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("midReset busy", {31'd0, busy}, 32'd0);
        prevResult = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            checkOutput("postReset rdy", {31'd0, data_resultRDY}, 32'd0);
            checkOutput("postReset busy", {31'd0, busy}, 32'd0);
        end

        // Random operands against the plain shift definition, alternating chained and idle.
        for (int n = 0; n < 1000; n++) begin
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            applyStimulus(a, sh);
            waitResult("random", a << sh, 1'b0);
            if (n[0]) begin
                checkIdle("random");
            end
        end
        checkIdle("final");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
